// File: rtl/symbol_pkg.sv
// Shared types and sizing for the symbol packer and for downstream word consumers.
package symbol_pkg;

  localparam int SYM_WIDTH     = 2;
  localparam int SYMS_PER_WORD = 4;
  localparam int WORD_WIDTH    = SYM_WIDTH * SYMS_PER_WORD;
  localparam int LEN_WIDTH     = $clog2(SYMS_PER_WORD) + 1;
  localparam int CNT_WIDTH     = $clog2(SYMS_PER_WORD);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic [LEN_WIDTH-1:0]  len;
    logic                  last;
  } word_t;

endpackage

// File: rtl/packer_out_slot.sv
// Single-entry valid/ready holding register for packed words.
module packer_out_slot
  import symbol_pkg::*;
(
  input  logic  CLK,
  input  logic  ASYNCRESETN,
  input  logic  i_load,
  input  word_t i_word,
  input  logic  i_ready,
  output word_t o_word,
  output logic  o_valid,
  output logic  o_free
);

  word_t r_word;
  logic  r_valid;

  // The parent only loads when o_free is high, so a load always wins over a take.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_word  = r_word;
  assign o_valid = r_valid;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/symbol_packer.sv
// Packs 2-bit symbols, least-significant first, into 8-bit words with length and last marker.
module symbol_packer
  import symbol_pkg::*;
(
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic [SYM_WIDTH-1:0]  sym_I,
  input  logic                  sym_valid,
  input  logic                  sym_last,
  output logic                  sym_ready,
  output logic [WORD_WIDTH-1:0] word_O,
  output logic [LEN_WIDTH-1:0]  word_len_O,
  output logic                  word_last_O,
  output logic                  word_valid,
  input  logic                  word_ready
);

  logic [WORD_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_outFree;
  logic                  w_lastSlot;
  logic                  w_complete;
  logic                  w_accept;
  logic                  w_load;
  logic [WORD_WIDTH-1:0] w_merged;
  word_t                 w_newWord;
  word_t                 w_slotWord;

  assign w_lastSlot = (r_cnt == CNT_WIDTH'(SYMS_PER_WORD - 1));
  assign w_complete = w_lastSlot || sym_last;

  // Only the word-completing symbol needs the output slot, so only it is stalled.
  assign sym_ready  = ASYNCRESETN && (w_outFree || (!w_lastSlot && !sym_last));
  assign w_accept   = sym_valid && sym_ready;
  assign w_load     = w_accept && w_complete;

  always_comb begin
    w_merged = r_acc;
    for (int i = 0; i < SYMS_PER_WORD; i++) begin
      if (r_cnt == CNT_WIDTH'(i)) begin
        w_merged[i*SYM_WIDTH +: SYM_WIDTH] = sym_I;
      end
    end
    w_newWord.data = w_merged;
    w_newWord.len  = LEN_WIDTH'(r_cnt) + LEN_WIDTH'(1);
    w_newWord.last = sym_last;
  end

  // Slices above cnt stay zero because the accumulator clears on every completion.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_merged;
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  packer_out_slot u_slot (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .i_load      (w_load),
    .i_word      (w_newWord),
    .i_ready     (word_ready),
    .o_word      (w_slotWord),
    .o_valid     (word_valid),
    .o_free      (w_outFree)
  );

  assign word_O      = w_slotWord.data;
  assign word_len_O  = w_slotWord.len;
  assign word_last_O = w_slotWord.last;

endmodule
